// File: rtl/keypad_seg_display.sv
// Keypad entry with debounce and cursor editing, plus a time-multiplexed
// seven-segment scan of the committed display buffer.
module keypad_seg_display #(
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned DEBOUNCE   = 4,
    parameter int unsigned SCAN_DIV   = 1000,
    localparam int unsigned CW        = $clog2(NUM_DIGITS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [11:0]             keypad_in,
    output logic                    key_valid,
    output logic [3:0]              key_code,
    output logic [CW-1:0]           cursor,
    output logic [7*NUM_DIGITS-1:0] edit_seg,
    output logic                    commit,
    output logic [6:0]              data_out,
    output logic [NUM_DIGITS-1:0]   data_pos
);

    localparam int unsigned DW = $clog2(DEBOUNCE + 1);
    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [0:0] {StIdle, StHeld} state_e;

    function automatic logic [6:0] seg_pattern(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'h3F;
            4'd1:    p = 7'h06;
            4'd2:    p = 7'h5B;
            4'd3:    p = 7'h4F;
            4'd4:    p = 7'h66;
            4'd5:    p = 7'h6D;
            4'd6:    p = 7'h7D;
            4'd7:    p = 7'h07;
            4'd8:    p = 7'h7F;
            4'd9:    p = 7'h6F;
            default: p = 7'h00;
        endcase
        return p;
    endfunction

    state_e                       state_q, state_d;
    logic [11:0]                  sample_q;
    logic [DW-1:0]                cnt_q;
    logic                         key_valid_q, key_valid_d;
    logic [3:0]                   key_code_q, key_code_d;
    logic [CW-1:0]                cursor_q, cursor_d;
    logic                         commit_q, commit_d;
    logic [NUM_DIGITS-1:0][6:0]   edit_q, edit_d;
    logic [NUM_DIGITS-1:0][6:0]   disp_q, disp_d;
    logic [PW-1:0]                presc_q;
    logic [CW-1:0]                scan_idx_q;

    logic       stable;
    logic       one_hot;
    logic       accept;
    logic [3:0] code;

    // Sampler: cnt_q counts repeats of sample_q, so cnt_q == DEBOUNCE-1 means
    // the last DEBOUNCE samples were identical.
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_q <= '0;
            cnt_q    <= '0;
        end else begin
            sample_q <= keypad_in;
            if (keypad_in != sample_q) begin
                cnt_q <= '0;
            end else if (cnt_q != DW'(DEBOUNCE)) begin
                cnt_q <= cnt_q + DW'(1);
            end
        end
    end

    assign stable  = (cnt_q >= DW'(DEBOUNCE - 1));
    assign one_hot = (sample_q != '0) && ((sample_q & (sample_q - 12'd1)) == '0);

    always_comb begin
        code = '0;
        for (int i = 0; i < 12; i++) begin
            if (sample_q[i]) begin
                code = 4'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (stable && one_hot) begin
                    accept  = 1'b1;
                    state_d = StHeld;
                end
            end
            StHeld: begin
                if (stable && (sample_q == '0)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        key_valid_d = accept;
        commit_d    = 1'b0;
        key_code_d  = key_code_q;
        cursor_d    = cursor_q;
        edit_d      = edit_q;
        disp_d      = disp_q;
        if (accept) begin
            key_code_d = code;
            if (code < 4'd10) begin
                edit_d[cursor_q] = seg_pattern(code);
            end else if (code == 4'd10) begin
                disp_d   = edit_q;
                commit_d = 1'b1;
                cursor_d = '0;
            end else begin
                cursor_d = (cursor_q == CW'(NUM_DIGITS - 1)) ? '0 : cursor_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
            cursor_q    <= '0;
            commit_q    <= 1'b0;
            edit_q      <= '0;
            disp_q      <= '0;
        end else begin
            state_q     <= state_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            cursor_q    <= cursor_d;
            commit_q    <= commit_d;
            edit_q      <= edit_d;
            disp_q      <= disp_d;
        end
    end

    // Scan runs free of key activity.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q    <= '0;
            scan_idx_q <= '0;
        end else if (presc_q == PW'(SCAN_DIV - 1)) begin
            presc_q    <= '0;
            scan_idx_q <= (scan_idx_q == CW'(NUM_DIGITS - 1)) ? '0 : scan_idx_q + CW'(1);
        end else begin
            presc_q <= presc_q + PW'(1);
        end
    end

    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign cursor    = cursor_q;
    assign commit    = commit_q;
    assign edit_seg  = edit_q;
    assign data_out  = disp_q[scan_idx_q];
    assign data_pos  = NUM_DIGITS'(1) << scan_idx_q;

endmodule

// File: doc/keypad_seg_display.md
# keypad_seg_display

Parametrised keypad-entry and multiplexed seven-segment display controller for the lab board. It debounces a 12-key one-hot keypad and edits an N-digit segment buffer at a cursor. `#` moves the cursor and `*` commits the edit buffer to the display buffer. A time-multiplexed scan drives one digit at a time onto shared segment lines. It sits between the raw keypad pins and the board's common-segment display.

## Interface
- NUM_DIGITS, 8, number of display digits (2..16); CW = $clog2(NUM_DIGITS)
- DEBOUNCE, 4, consecutive identical samples required to accept a key press or release (>=1)
- SCAN_DIV, 1000, clk cycles each digit is driven during scan (>=1)

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- keypad_in  in  12  raw keys: bits 0-9 = digits 0-9, bit 10 = `*`, bit 11 = `#`; active-high, asynchronous to nothing (already clk-domain)
- key_valid  out  1  one-cycle pulse per accepted press
- key_code  out  4  code of last accepted key (0-9, 10=`*`, 11=`#`); held until next press
- cursor  out  CW  edit position
- edit_seg  out  7*NUM_DIGITS  edit buffer, digit i at [7i+6:7i]
- commit  out  1  one-cycle pulse when `*` copies edit buffer to display buffer
- data_out  out  7  segments of currently scanned digit, bit0=a..bit6=g, active-high
- data_pos  out  NUM_DIGITS  one-hot digit enable, active-high

## Operation
- Segment encoding: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F; blank=0x00.
- Sampler: keypad_in is registered every cycle. A stability counter resets when the sample differs from the previous sample and otherwise increments, saturating at DEBOUNCE.
- FSM state IDLE:
  - A press is accepted when the last DEBOUNCE samples are an identical single-hot value.
  - On acceptance, go to HELD and execute the key action.
  - Zero or multi-hot values are ignored.
- FSM state HELD:
  - Go to IDLE when the last DEBOUNCE samples are all zero.
  - Any nonzero value, including a different or multi-hot value, keeps the FSM in HELD. There is no auto-repeat.
- Key actions, all taking effect at the accepting edge with key_valid=1 and key_code updated:
  - Digit d: edit buffer[cursor] <= pattern(d). The cursor does not move.
  - `#`: cursor <= cursor+1. It wraps from NUM_DIGITS-1 to 0.
  - `*`: display buffer <= edit buffer; commit=1; cursor <= 0. The edit buffer is kept.
- Scan:
  - The prescaler counts 0..SCAN_DIV-1. At the edge where it equals SCAN_DIV-1, it returns to 0 and the scan index advances, wrapping from NUM_DIGITS-1 to 0.
  - data_pos = 1<<index and data_out = display buffer[index]. Both are combinational from registers.
  - Scan runs continuously, independent of key activity.

## Timing
- Reset values:
  - FSM=IDLE, stability counter=0, sample register=0.
  - Both buffers all 0x00, cursor=0, key_valid=0, key_code=0, commit=0.
  - Prescaler=0, scan index=0, so data_pos=1 and data_out=0x00.
- Press latency: keypad_in is stable from before edge 1. key_valid, key_code, cursor, edit_seg and commit update at edge DEBOUNCE+1: one sampler edge plus DEBOUNCE stable samples.
- A commit is visible on data_out in the same cycle the commit pulse is high, if the scanned digit changed.
- Boundary conditions:
  - Bounce shorter than DEBOUNCE samples never produces a press.
  - Release bounce never produces a second press.
- Reset mid-operation, in HELD or mid-debounce: returns to IDLE. A key still held after reset is accepted once after DEBOUNCE stable samples.
- SCAN_DIV=1: index advances every cycle.

## Test plan
- Reset: assert rst 2 cycles with keypad_in=0x020 -> all outputs at reset values, data_pos=0x01, no key_valid during rst.
- Digit press (defaults): keypad_in=0x020 held 10 cycles -> key_valid exactly once at edge 5 after change, key_code=5, edit_seg[6:0]=0x6D, cursor=0, commit=0, data_out still 0x00.
- Bounce: keypad_in alternates 0x004/0x000 every 2 cycles for 20 cycles, then 0x004 stable 10 cycles, then 0x000 with same bounce -> exactly one key_valid, key_code=2.
- Cursor wrap: nine `#` presses (0x800) separated by releases -> cursor 1,2,…,7,0,1; edit_seg unchanged.
- Commit and scan (SCAN_DIV=3):
  - Stimulus: press 1, `#`, 2, `*`.
  - Required response: commit pulses once and cursor=0.
  - data_pos=0x01 shows data_out=0x06 and data_pos=0x02 shows 0x5B, each for 3 cycles; other digits show 0x00.
- Illegal/held: keypad_in=0x003 for 20 cycles -> no key_valid. Press 0x001 and switch directly to 0x010 without release -> no second press. Pulse rst while held -> one press accepted after DEBOUNCE samples.
